// File: rtl/fbindct_pkg.sv
// Shared definitions for the fbindct BRAM arbiter: owner encoding, FSM states
// and a ceil(log2) helper used for counter sizing.
package fbindct_pkg;

  localparam logic [1:0] OWN_NONE = 2'd0;
  localparam logic [1:0] OWN_C0   = 2'd1;
  localparam logic [1:0] OWN_C1   = 2'd2;

  // State encoding doubles as the current owner of the BRAM port.
  typedef enum logic [1:0] {
    IDLE = OWN_NONE,
    OWN0 = OWN_C0,
    OWN1 = OWN_C1
  } state_e;

  function automatic int clogb2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r = r + 1;
    return r;
  endfunction

endpackage

// File: rtl/fbindct_rd_tag_pipe.sv
// Shift register of {valid, client} read tags; its output lines up with the
// BRAM read data of the beat that inserted the tag.
module fbindct_rd_tag_pipe #(
  parameter int DEPTH = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic i_valid,
  input  logic i_client,
  output logic o_valid,
  output logic o_client
);

  logic [DEPTH-1:0] r_valid;
  logic [DEPTH-1:0] r_client;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid  <= '0;
      r_client <= '0;
    end else begin
      r_valid  <= {r_valid[DEPTH-2:0], i_valid};
      r_client <= {r_client[DEPTH-2:0], i_client};
    end
  end

  assign o_valid  = r_valid[DEPTH-1];
  assign o_client = r_client[DEPTH-1];

endmodule

// File: rtl/fbindct_bram_arbiter.sv
// Shares one BRAM port between the row-fetch reader (c0) and the coefficient
// store writer (c1): round-robin, bounded bursts, optional lock, tagged reads.
module fbindct_bram_arbiter
  import fbindct_pkg::*;
#(
  parameter int DATA_WIDTH   = 32,
  parameter int ADDR_WIDTH   = 13,
  parameter int MAX_BURST    = 8,
  parameter int READ_LATENCY = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  c0_req,
  input  logic                  c0_we,
  input  logic                  c0_lock,
  input  logic [ADDR_WIDTH-1:0] c0_addr,
  input  logic [DATA_WIDTH-1:0] c0_wdata,
  output logic                  c0_ack,
  output logic                  c0_rvalid,
  input  logic                  c1_req,
  input  logic                  c1_we,
  input  logic                  c1_lock,
  input  logic [ADDR_WIDTH-1:0] c1_addr,
  input  logic [DATA_WIDTH-1:0] c1_wdata,
  output logic                  c1_ack,
  output logic                  c1_rvalid,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic [ADDR_WIDTH-1:0] bram_addr,
  output logic [DATA_WIDTH-1:0] bram_wrdata,
  output logic                  bram_en,
  output logic                  bram_we,
  input  logic [DATA_WIDTH-1:0] bram_rddata
);

  localparam int CNT_W = (clogb2(MAX_BURST) > 0) ? clogb2(MAX_BURST) : 1;
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(MAX_BURST - 1);

  state_e                r_state;
  logic                  r_rr_ptr;
  logic [CNT_W-1:0]      r_beat_cnt;
  logic [ADDR_WIDTH-1:0] r_bram_addr;
  logic [DATA_WIDTH-1:0] r_bram_wrdata;
  logic                  r_bram_en;
  logic                  r_bram_we;

  logic                  w_own1;
  logic                  w_owned;
  logic                  w_req_x;
  logic                  w_req_y;
  logic                  w_lock_x;
  logic                  w_we_x;
  logic [ADDR_WIDTH-1:0] w_addr_x;
  logic [DATA_WIDTH-1:0] w_wdata_x;
  logic                  w_ack;
  logic                  w_last;
  state_e                w_other;
  logic                  w_tag_valid;
  logic                  w_tag_client;

  // x = current owner, y = the other client
  assign w_own1    = (r_state == OWN1);
  assign w_owned   = (r_state != IDLE);
  assign w_req_x   = w_own1 ? c1_req   : c0_req;
  assign w_req_y   = w_own1 ? c0_req   : c1_req;
  assign w_lock_x  = w_own1 ? c1_lock  : c0_lock;
  assign w_we_x    = w_own1 ? c1_we    : c0_we;
  assign w_addr_x  = w_own1 ? c1_addr  : c0_addr;
  assign w_wdata_x = w_own1 ? c1_wdata : c0_wdata;
  assign w_other   = w_own1 ? OWN0 : OWN1;
  assign w_ack     = w_owned & w_req_x;
  assign w_last    = (r_beat_cnt == LAST_BEAT);

  assign c0_ack = (r_state == OWN0) & c0_req;
  assign c1_ack = (r_state == OWN1) & c1_req;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= IDLE;
      r_rr_ptr      <= 1'b0;
      r_beat_cnt    <= '0;
      r_bram_addr   <= '0;
      r_bram_wrdata <= '0;
      r_bram_en     <= 1'b0;
      r_bram_we     <= 1'b0;
    end else begin
      r_bram_en <= w_ack;
      r_bram_we <= w_ack & w_we_x;
      if (w_ack) begin
        r_bram_addr   <= w_addr_x;
        r_bram_wrdata <= w_wdata_x;
      end
      case (r_state)
        IDLE: begin
          if (c0_req && c1_req) r_state <= r_rr_ptr ? OWN1 : OWN0;
          else if (c0_req)      r_state <= OWN0;
          else if (c1_req)      r_state <= OWN1;
        end
        default: begin
          if (!w_req_x) begin
            r_state    <= w_req_y ? w_other : IDLE;
            r_beat_cnt <= '0;
            r_rr_ptr   <= ~w_own1;
          end else if (w_last) begin
            // Lock keeps ownership; the counter still wraps.
            r_beat_cnt <= '0;
            if (!w_lock_x) begin
              r_rr_ptr <= ~w_own1;
              if (w_req_y) r_state <= w_other;
            end
          end else begin
            r_beat_cnt <= r_beat_cnt + 1'b1;
          end
        end
      endcase
    end
  end

  fbindct_rd_tag_pipe #(
    .DEPTH (READ_LATENCY + 1)
  ) u_tag_pipe (
    .clk      (clk),
    .rst      (rst),
    .i_valid  (w_ack & ~w_we_x),
    .i_client (w_own1),
    .o_valid  (w_tag_valid),
    .o_client (w_tag_client)
  );

  assign c0_rvalid   = w_tag_valid & ~w_tag_client;
  assign c1_rvalid   = w_tag_valid &  w_tag_client;
  assign rd_data     = bram_rddata;
  assign bram_addr   = r_bram_addr;
  assign bram_wrdata = r_bram_wrdata;
  assign bram_en     = r_bram_en;
  assign bram_we     = r_bram_we;

endmodule
